rc4_key_search: RTL

RC4_KEY_SEARCH -- requirements
Module: rc4_key_search

---
 rtl/rc4_key_search.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rc4_key_search.sv
// rc4_key_search
//
// Brute-force key search controller for an external RC4 keystream core.
// Walks every candidate key in an inclusive range [key_lo, key_hi], lets the
// core produce its M_BYTES_LEN-byte output for that key, and accepts the key
// when every output byte is printable ASCII (0x20..0x7E). Bytes are tested
// one per cycle, most-significant byte first, so a bad candidate is dropped
// at its first non-printable byte.
//
// Ports
//   clk             rising-edge clock for all logic
//   reset           synchronous active-high reset, dominates every input
//   start           one-cycle launch pulse, honoured only while idle
//   abort           ends a running search and returns to idle
//   key_lo, key_hi  inclusive candidate range, sampled on start
//   core_enable     enable to the RC4 core (high through RUN and CHECK)
//   core_key        current candidate key presented to the core
//   core_bytes_out  keystream/output bytes from the core
//   core_done       one-cycle pulse from the core, core_bytes_out valid then
//   busy            high whenever the controller is not idle
//   found           high from a successful search until next start/reset
//   exhausted       high from an unsuccessful search until next start/reset
//   key_found       matching key, valid while found is high
//   plaintext       core output for the matching key, valid while found
module rc4_key_search #(
  parameter int K_BYTES_LEN = 3,
  parameter int M_BYTES_LEN = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [K_BYTES_LEN*8-1:0] key_lo,
  input  logic [K_BYTES_LEN*8-1:0] key_hi,
  output logic                     core_enable,
  output logic [K_BYTES_LEN*8-1:0] core_key,
  input  logic [M_BYTES_LEN*8-1:0] core_bytes_out,
  input  logic                     core_done,
  output logic                     busy,
  output logic                     found,
  output logic                     exhausted,
  output logic [K_BYTES_LEN*8-1:0] key_found,
  output logic [M_BYTES_LEN*8-1:0] plaintext
);

  localparam int KW    = K_BYTES_LEN * 8;
  localparam int MW    = M_BYTES_LEN * 8;
  localparam int IDX_W = (M_BYTES_LEN > 1) ? $clog2(M_BYTES_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(M_BYTES_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    CHECK,
    RELEASE,
    FOUND,
    EXHAUST
  } state_t;

  state_t           state;
  logic [KW-1:0]    cand;
  logic [KW-1:0]    hi;
  logic [MW-1:0]    chk;
  logic [IDX_W-1:0] idx;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  // Shift-based byte select keeps the index arithmetic width-clean for any
  // message length.
  function automatic logic [7:0] byte_at(input logic [MW-1:0] v,
                                         input logic [IDX_W-1:0] i);
    logic [MW-1:0] sh;
    sh = v >> {i, 3'b000};
    return sh[7:0];
  endfunction

  logic cur_ok;
  assign cur_ok   = is_printable(byte_at(chk, idx));

  // The candidate register only moves in RELEASE, so the key seen by the
  // core is constant across each RUN/CHECK interval.
  assign core_key = cand;

  // Control FSM with registered outputs. core_enable and busy are updated
  // together with every transition so they always match the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      core_enable <= 1'b0;
      busy        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      key_found   <= '0;
      plaintext   <= '0;
      cand        <= '0;
      idx         <= '0;
    end else if (abort && (state != IDLE)) begin
      // Abort beats a same-cycle core_done; result flags are left alone.
      state       <= IDLE;
      core_enable <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            found     <= 1'b0;
            exhausted <= 1'b0;
            busy      <= 1'b1;
            if (key_lo > key_hi) begin
              state <= EXHAUST;
            end else begin
              cand        <= key_lo;
              state       <= RUN;
              core_enable <= 1'b1;
            end
          end
        end

        RUN: begin
          if (core_done) begin
            idx   <= IDX_TOP;
            state <= CHECK;
          end
        end

        CHECK: begin
          if (!cur_ok) begin
            state       <= RELEASE;
            core_enable <= 1'b0;
          end else if (idx == '0) begin
            state       <= FOUND;
            core_enable <= 1'b0;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end

        RELEASE: begin
          // Compare before incrementing so an all-ones upper bound ends the
          // search instead of wrapping the candidate to zero.
          if (cand == hi) begin
            state <= EXHAUST;
          end else begin
            cand        <= cand + KW'(1);
            state       <= RUN;
            core_enable <= 1'b1;
          end
        end

        FOUND: begin
          key_found <= cand;
          plaintext <= chk;
          found     <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        EXHAUST: begin
          exhausted <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state       <= IDLE;
          core_enable <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers: upper bound and the captured core output. They need
  // no reset; they are always loaded before being used.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if ((state == IDLE) && start) begin
        hi <= key_hi;
      end
      if ((state == RUN) && core_done && !abort) begin
        chk <= core_bytes_out;
      end
    end
  end

endmodule
